// File: rtl/layer_mem_pkg.sv
// Shared types and widths for the layer-memory port and its arbiter.
package layer_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 13;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_e;

    typedef struct packed {
        logic              we;
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/lm_wait_counter.sv
// Counts consecutive cycles a requester waits without a grant; flags starvation at MAX_WAIT.
module lm_wait_counter #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic gnt_i,
    output logic starved_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates so a master that loses a double-starvation tie stays starved.
    always_comb begin
        cnt_d = '0;
        if (req_i && !gnt_i) begin
            cnt_d = (cnt_q == CW'(MAX_WAIT)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/layer_mem_arbiter.sv
// Two-master arbiter for the layer-memory port: ownership locking, starvation
// override and a two-stage tag pipeline that routes read data back in order.
module layer_mem_arbiter
    import layer_mem_pkg::*;
#(
    parameter int PRIORITY = 0,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_sel,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_sel,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              cwr,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic              csel,
    input  logic [DATA_W-1:0] cdata_rd,
    output own_state_e        dbg_state_o
);

    own_state_e state_q;
    logic       rr_last_q;   // 1: m1 was granted most recently
    logic       rd1_vld_q, rd1_tag_q, rd2_vld_q, rd2_tag_q;
    logic       starved0, starved1;
    logic       gnt0, gnt1, xfer0, xfer1, xfer, win_lock;
    mem_cmd_t   m0_cmd, m1_cmd, win_cmd;

    lm_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait0 (
        .clk(clk), .reset(reset), .req_i(m0_req), .gnt_i(gnt0), .starved_o(starved0)
    );
    lm_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait1 (
        .clk(clk), .reset(reset), .req_i(m1_req), .gnt_i(gnt1), .starved_o(starved1)
    );

    // Starvation beats ownership and priority; m0 wins a double starvation.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (starved0 && m0_req) begin
            gnt0 = 1'b1;
        end else if (starved1 && m1_req) begin
            gnt1 = 1'b1;
        end else begin
            case (state_q)
                OWN0:    gnt0 = m0_req;
                OWN1:    gnt1 = m1_req;
                default: begin
                    if (m0_req && m1_req) begin
                        if (PRIORITY == 1 || rr_last_q) gnt0 = 1'b1;
                        else                            gnt1 = 1'b1;
                    end else begin
                        gnt0 = m0_req;
                        gnt1 = m1_req;
                    end
                end
            endcase
        end
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign m0_gnt   = gnt0;
    assign m1_gnt   = gnt1;
    assign xfer0    = m0_req && gnt0;
    assign xfer1    = m1_req && gnt1;
    assign xfer     = xfer0 || xfer1;
    assign m0_cmd   = '{we: m0_we, sel: m0_sel, addr: m0_addr, wdata: m0_wdata};
    assign m1_cmd   = '{we: m1_we, sel: m1_sel, addr: m1_addr, wdata: m1_wdata};
    assign win_cmd  = xfer1 ? m1_cmd : m0_cmd;
    assign win_lock = xfer1 ? m1_lock : m0_lock;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FREE;
            rr_last_q <= 1'b1;
            cwr       <= 1'b0;
            crd       <= 1'b0;
            caddr     <= '0;
            cdata_wr  <= '0;
            csel      <= 1'b0;
            rd1_vld_q <= 1'b0;
            rd1_tag_q <= 1'b0;
            rd2_vld_q <= 1'b0;
            rd2_tag_q <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            cwr <= xfer && win_cmd.we;
            crd <= xfer && !win_cmd.we;
            if (xfer) begin
                caddr     <= win_cmd.addr;
                cdata_wr  <= win_cmd.wdata;
                csel      <= win_cmd.sel;
                rr_last_q <= xfer1;
                state_q   <= win_lock ? (xfer1 ? OWN1 : OWN0) : FREE;
            end else if ((state_q == OWN0 && !m0_req && !m0_lock) ||
                         (state_q == OWN1 && !m1_req && !m1_lock)) begin
                state_q <= FREE;
            end
            // Tag travels alongside the memory's one-cycle read latency.
            rd1_vld_q <= xfer && !win_cmd.we;
            rd1_tag_q <= xfer1;
            rd2_vld_q <= rd1_vld_q;
            rd2_tag_q <= rd1_tag_q;
            m0_rvalid <= rd2_vld_q && !rd2_tag_q;
            m1_rvalid <= rd2_vld_q && rd2_tag_q;
            if (rd2_vld_q && !rd2_tag_q) m0_rdata <= cdata_rd;
            if (rd2_vld_q && rd2_tag_q)  m1_rdata <= cdata_rd;
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Bench: round-robin and fixed-priority arbiters share one stimulus stream; a
// transaction-level model predicts grants, memory commands and read returns.
module tb_layer_mem_arbiter;
  import layer_mem_pkg::*;

  localparam int MAXW = 16;

  logic clk, reset;
  logic m0_req, m0_we, m0_sel, m0_lock, m1_req, m1_we, m1_sel, m1_lock;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;

  logic [1:0] g0_w, g1_w, rv0_w, rv1_w, cwr_w, crd_w, csel_w;
  logic [DATA_W-1:0] rd0_w [2];
  logic [DATA_W-1:0] rd1_w [2];
  logic [DATA_W-1:0] cdw_w [2];
  logic [DATA_W-1:0] cdr_w [2];
  logic [ADDR_W-1:0] caddr_w [2];
  own_state_e st_w [2];

  layer_mem_arbiter #(.PRIORITY(0), .MAX_WAIT(MAXW)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(g0_w[0]), .m0_rvalid(rv0_w[0]), .m0_rdata(rd0_w[0]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(g1_w[0]), .m1_rvalid(rv1_w[0]), .m1_rdata(rd1_w[0]),
    .cwr(cwr_w[0]), .crd(crd_w[0]), .caddr(caddr_w[0]), .cdata_wr(cdw_w[0]), .csel(csel_w[0]),
    .cdata_rd(cdr_w[0]), .dbg_state_o(st_w[0])
  );

  layer_mem_arbiter #(.PRIORITY(1), .MAX_WAIT(MAXW)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(g0_w[1]), .m0_rvalid(rv0_w[1]), .m0_rdata(rd0_w[1]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(g1_w[1]), .m1_rvalid(rv1_w[1]), .m1_rdata(rd1_w[1]),
    .cwr(cwr_w[1]), .crd(crd_w[1]), .caddr(caddr_w[1]), .cdata_wr(cdw_w[1]), .csel(csel_w[1]),
    .cdata_rd(cdr_w[1]), .dbg_state_o(st_w[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- memory stand-ins (one per DUT) ----------------
  logic [DATA_W-1:0] mem [2][2][4096];
  logic [DATA_W-1:0] ref_mem [2][2][4096];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 2; s++)
        for (int a = 0; a < 4096; a++) begin
          mem[k][s][a] = DATA_W'(a * 7 + s * 100 + 3);
          ref_mem[k][s][a] = DATA_W'(a * 7 + s * 100 + 3);
        end
    cdr_w[0] = '0;
    cdr_w[1] = '0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (crd_w[k]) cdr_w[k] <= mem[k][csel_w[k]][caddr_w[k]];
      if (cwr_w[k]) mem[k][csel_w[k]][caddr_w[k]] <= cdw_w[k];
    end
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int rv_cnt [2][2];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
  endtask

  typedef struct {
    int due;
    int k;
    int m;
    logic [DATA_W-1:0] data;
  } rd_ev_t;
  rd_ev_t exp_q[$];

  int owner [2];
  int last_g [2];
  int wcnt [2][2];
  logic exp_cwr [2];
  logic exp_crd [2];
  logic exp_csel [2];
  logic [ADDR_W-1:0] exp_caddr [2];
  logic [DATA_W-1:0] exp_cdw [2];
  logic [DATA_W-1:0] exp_rd [2][2];

  task automatic model_reset(input int k);
    owner[k] = -1;
    last_g[k] = 1;
    wcnt[k][0] = 0;
    wcnt[k][1] = 0;
    exp_cwr[k] = 1'b0;
    exp_crd[k] = 1'b0;
    exp_csel[k] = 1'b0;
    exp_caddr[k] = '0;
    exp_cdw[k] = '0;
    exp_rd[k][0] = '0;
    exp_rd[k][1] = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].k == k) exp_q.delete(i);
  endtask

  // Instance 0 arbitrates round-robin, instance 1 gives m0 fixed priority.
  task automatic model_gnt(input int k, output bit g0, output bit g1);
    g0 = 0;
    g1 = 0;
    if (reset) return;
    if (m0_req && wcnt[k][0] == MAXW) g0 = 1;
    else if (m1_req && wcnt[k][1] == MAXW) g1 = 1;
    else if (owner[k] == 0) g0 = m0_req;
    else if (owner[k] == 1) g1 = m1_req;
    else if (m0_req && m1_req) begin
      if (k == 1 || last_g[k] == 1) g0 = 1;
      else g1 = 1;
    end else begin
      g0 = m0_req;
      g1 = m1_req;
    end
  endtask

  task automatic model_cycle(input int k);
    bit g0, g1, ev0, ev1;
    int w;
    logic we, sel, lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    own_state_e exp_st;
    if (reset) model_reset(k);
    ev0 = 0;
    ev1 = 0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].k == k && exp_q[i].due == cyc) begin
        if (exp_q[i].m == 0) begin ev0 = 1; exp_rd[k][0] = exp_q[i].data; end
        else begin ev1 = 1; exp_rd[k][1] = exp_q[i].data; end
        exp_q.delete(i);
      end
    end
    model_gnt(k, g0, g1);
    exp_st = (owner[k] == 0) ? OWN0 : (owner[k] == 1) ? OWN1 : FREE;
    chk("m0_gnt", k, 32'(g0_w[k]), 32'(g0));
    chk("m1_gnt", k, 32'(g1_w[k]), 32'(g1));
    chk("cwr", k, 32'(cwr_w[k]), 32'(exp_cwr[k]));
    chk("crd", k, 32'(crd_w[k]), 32'(exp_crd[k]));
    chk("caddr", k, 32'(caddr_w[k]), 32'(exp_caddr[k]));
    chk("cdata_wr", k, 32'(cdw_w[k]), 32'(exp_cdw[k]));
    chk("csel", k, 32'(csel_w[k]), 32'(exp_csel[k]));
    chk("m0_rvalid", k, 32'(rv0_w[k]), 32'(ev0));
    chk("m1_rvalid", k, 32'(rv1_w[k]), 32'(ev1));
    chk("m0_rdata", k, 32'(rd0_w[k]), 32'(exp_rd[k][0]));
    chk("m1_rdata", k, 32'(rd1_w[k]), 32'(exp_rd[k][1]));
    chk("state", k, 32'(st_w[k]), 32'(exp_st));
    if (rv0_w[k]) rv_cnt[k][0]++;
    if (rv1_w[k]) rv_cnt[k][1]++;
    if (reset) return;
    w = g0 ? 0 : (g1 ? 1 : -1);
    if (w >= 0) begin
      we    = (w == 0) ? m0_we : m1_we;
      sel   = (w == 0) ? m0_sel : m1_sel;
      lock  = (w == 0) ? m0_lock : m1_lock;
      addr  = (w == 0) ? m0_addr : m1_addr;
      wdata = (w == 0) ? m0_wdata : m1_wdata;
      exp_cwr[k] = we;
      exp_crd[k] = !we;
      exp_caddr[k] = addr;
      exp_cdw[k] = wdata;
      exp_csel[k] = sel;
      if (we) ref_mem[k][sel][addr] = wdata;
      else exp_q.push_back('{due: cyc + 3, k: k, m: w, data: ref_mem[k][sel][addr]});
      owner[k] = lock ? w : -1;
      last_g[k] = w;
    end else begin
      exp_cwr[k] = 1'b0;
      exp_crd[k] = 1'b0;
      if (owner[k] == 0 && !m0_req && !m0_lock) owner[k] = -1;
      if (owner[k] == 1 && !m1_req && !m1_lock) owner[k] = -1;
    end
    wcnt[k][0] = (m0_req && !g0) ? ((wcnt[k][0] < MAXW) ? wcnt[k][0] + 1 : MAXW) : 0;
    wcnt[k][1] = (m1_req && !g1) ? ((wcnt[k][1] < MAXW) ? wcnt[k][1] + 1 : MAXW) : 0;
  endtask

  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic sel,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input logic lock);
    m0_req = req; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic sel,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input logic lock);
    m1_req = req; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int base [2][2];
    int first_g1 [2];
    logic [7:0] pat [2];

    reset = 1'b1;
    drive_m0(1'b1, 1'b0, 1'b0, 12'h040, 13'h0, 1'b0);
    drive_m1(1'b0, 1'b0, 1'b0, 12'h0, 13'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin rv_cnt[k][0] = 0; rv_cnt[k][1] = 0; end
    repeat (3) tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("rst_gnt_gated", k, 32'(g0_w[k]), 32'd0);
    tick();

    // Read in flight when reset hits must never return.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive_m0(1'b0, 1'b0, 1'b0, 12'h040, 13'h0, 1'b0);
    for (int k = 0; k < 2; k++) base[k][0] = rv_cnt[k][0];
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 2; k++) chk("rst_drop_read", k, 32'(rv_cnt[k][0] - base[k][0]), 32'd0);

    // Single master write then read-back.
    drive_m0(1'b1, 1'b1, 1'b1, 12'd5, 13'h0123, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("single_gnt", k, 32'(g0_w[k]), 32'd1);
    tick();
    drive_m0(1'b1, 1'b0, 1'b1, 12'd5, 13'h0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("wr_cwr", k, 32'(cwr_w[k]), 32'd1);
      chk("wr_csel", k, 32'(csel_w[k]), 32'd1);
      chk("wr_caddr", k, 32'(caddr_w[k]), 32'd5);
      chk("wr_cdata", k, 32'(cdw_w[k]), 32'h0123);
    end
    tick();
    drive_m0(1'b0, 1'b0, 1'b0, 12'd0, 13'h0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("rd_crd", k, 32'(crd_w[k]), 32'd1);
    tick();
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rd_rvalid", k, 32'(rv0_w[k]), 32'd1);
      chk("rd_rdata", k, 32'(rd0_w[k]), 32'h0123);
    end
    tick();

    // m1 preload, then both masters contend with lock=0.
    drive_m1(1'b1, 1'b1, 1'b0, 12'd7, 13'h0abc, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin base[k][0] = rv_cnt[k][0]; base[k][1] = rv_cnt[k][1]; end
    drive_m0(1'b1, 1'b0, 1'b1, 12'd5, 13'h0, 1'b0);
    drive_m1(1'b1, 1'b0, 1'b0, 12'd7, 13'h0, 1'b0);
    pat[0] = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[0][i] = g0_w[0];
      tick();
    end
    drive_m0(1'b0, 1'b0, 1'b0, 12'd0, 13'h0, 1'b0);
    drive_m1(1'b0, 1'b0, 1'b0, 12'd0, 13'h0, 1'b0);
    repeat (4) tick();
    chk("rr_alternate", 0, 32'(pat[0]), 32'h55);
    chk("rr_m0_reads", 0, 32'(rv_cnt[0][0] - base[0][0]), 32'd4);
    chk("rr_m1_reads", 0, 32'(rv_cnt[0][1] - base[0][1]), 32'd4);
    chk("fp_m0_reads", 1, 32'(rv_cnt[1][0] - base[1][0]), 32'd8);
    chk("fp_m1_reads", 1, 32'(rv_cnt[1][1] - base[1][1]), 32'd0);
    chk("rr_m1_rdata", 0, 32'(rd1_w[0]), 32'h0abc);

    // Fixed priority starvation of m1.
    drive_m0(1'b1, 1'b0, 1'b1, 12'd5, 13'h0, 1'b0);
    drive_m1(1'b1, 1'b0, 1'b0, 12'd7, 13'h0, 1'b0);
    first_g1[1] = 0;
    for (int i = 1; i <= 40 && first_g1[1] == 0; i++) begin
      @(negedge clk);
      if (g1_w[1]) first_g1[1] = i;
      tick();
    end
    drive_m1(1'b0, 1'b0, 1'b0, 12'd0, 13'h0, 1'b0);
    chk("starve_wait", 1, 32'(first_g1[1]), 32'd17);
    @(negedge clk);
    chk("m0_resume", 1, 32'(g0_w[1]), 32'd1);
    tick();
    drive_m0(1'b0, 1'b0, 1'b0, 12'd0, 13'h0, 1'b0);
    repeat (4) tick();

    // m1 locked 4-read burst while m0 keeps requesting.
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive_m1(1'b1, 1'b0, 1'b0, 12'(i), 13'h0, (i < 3) ? 1'b1 : 1'b0);
      else drive_m1(1'b0, 1'b0, 1'b0, 12'd0, 13'h0, 1'b0);
      if (i >= 1) drive_m0(1'b1, 1'b0, 1'b1, 12'd5, 13'h0, 1'b0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        pat[k][i] = rv1_w[k];
        if (i < 4) begin
          chk("burst_m0_blocked", k, 32'(g0_w[k]), 32'd0);
          chk("burst_m1_gnt", k, 32'(g1_w[k]), 32'd1);
        end
        if (i == 4) chk("burst_release_m0", k, 32'(g0_w[k]), 32'd1);
      end
      tick();
    end
    drive_m0(1'b0, 1'b0, 1'b0, 12'd0, 13'h0, 1'b0);
    repeat (4) tick();
    for (int k = 0; k < 2; k++) chk("burst_rvalid_run", k, 32'(pat[k]), 32'h78);

    // m0 idles while holding lock; m1 is force-granted.
    drive_m0(1'b1, 1'b1, 1'b0, 12'd9, 13'h0777, 1'b1);
    tick();
    drive_m0(1'b0, 1'b0, 1'b0, 12'd0, 13'h0, 1'b1);
    drive_m1(1'b1, 1'b0, 1'b0, 12'd9, 13'h0, 1'b0);
    first_g1[0] = 0;
    first_g1[1] = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (g1_w[k] && first_g1[k] == 0) first_g1[k] = i;
        if (i == 18) begin
          chk("own0_cleared_gnt", k, 32'(g1_w[k]), 32'd1);
          chk("own0_cleared_state", k, 32'(st_w[k]), 32'(FREE));
        end
      end
      tick();
    end
    drive_m0(1'b0, 1'b0, 1'b0, 12'd0, 13'h0, 1'b0);
    drive_m1(1'b0, 1'b0, 1'b0, 12'd0, 13'h0, 1'b0);
    repeat (6) tick();
    for (int k = 0; k < 2; k++) begin
      chk("lock_force_wait", k, 32'(first_g1[k]), 32'd17);
      chk("lock_rdata", k, 32'(rd1_w[k]), 32'h0777);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
